// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simon_pkg
//  Brief    : Shared constants, z3 sequence and FSM state type for the
//             Simon 64/128 key-schedule unit.
//  Revision : 1.0 - initial release
// ============================================================================
package simon_pkg;

    localparam int SIMON_WORD_W    = 32;
    localparam int SIMON_KEY_WORDS = 4;
    localparam int SIMON_ROUNDS    = 44;
    localparam int SIMON_IDX_W     = 6;

    // Bit 0 holds the first element of the z3 sequence.
    localparam logic [61:0] SIMON_Z3 = 62'h3C2CE51207A635DB;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_EXPAND = 3'b010,
        ST_DONE   = 3'b100
    } simon_state_t;

    function automatic logic simon_z_bit(input logic [SIMON_IDX_W-1:0] round);
        logic [SIMON_IDX_W-1:0] w_pos;
        w_pos = (round >= 6'd62) ? (round - 6'd62) : round;
        return SIMON_Z3[w_pos];
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_key_expand_if.sv
`default_nettype none
// ============================================================================
//  Module   : simon_key_expand_if
//  Brief    : Control, master-key and round-key read bus of the key schedule.
//  Revision : 1.0 - initial release
// ============================================================================
interface simon_key_expand_if;
    import simon_pkg::*;

    logic                                    start;
    logic [SIMON_KEY_WORDS*SIMON_WORD_W-1:0] key_in;
    logic [SIMON_IDX_W-1:0]                  rk_addr;
    logic [SIMON_WORD_W-1:0]                 rk_data;
    logic                                    busy;
    logic                                    key_done;

    modport master (
        output start, key_in, rk_addr,
        input  rk_data, busy, key_done
    );

    modport slave (
        input  start, key_in, rk_addr,
        output rk_data, busy, key_done
    );

endinterface
`default_nettype wire

// File: rtl/simon_key_round.sv
`default_nettype none
// ============================================================================
//  Module   : simon_key_round
//  Brief    : Combinational Simon 64/128 key-schedule step k[i] from
//             k[i-4], k[i-3], k[i-1] and one z3 bit.
//  Revision : 1.0 - initial release
// ============================================================================
module simon_key_round #(
    parameter int WORD_W = 32
) (
    input  wire  [WORD_W-1:0] i_k_m4,
    input  wire  [WORD_W-1:0] i_k_m3,
    input  wire  [WORD_W-1:0] i_k_m1,
    input  wire               i_z,
    output logic [WORD_W-1:0] o_k
);

    localparam logic [WORD_W-1:0] c_round_const = WORD_W'(3);

    logic [WORD_W-1:0] w_tmp0;
    logic [WORD_W-1:0] w_tmp1;

    assign w_tmp0 = {i_k_m1[2:0], i_k_m1[WORD_W-1:3]} ^ i_k_m3;
    assign w_tmp1 = w_tmp0 ^ {w_tmp0[0], w_tmp0[WORD_W-1:1]};
    assign o_k    = ~i_k_m4 ^ w_tmp1 ^ {{(WORD_W-1){1'b0}}, i_z} ^ c_round_const;

endmodule
`default_nettype wire

// File: rtl/simon_key_expand.sv
`default_nettype none
// ============================================================================
//  Module   : simon_key_expand
//  Brief    : Simon 64/128 key schedule: loads a 128-bit key and expands 44
//             round keys, one per cycle, into a register file with a
//             registered read port. Option macro: SIMON_KEY_ZEROIZE_EN
//             (storage cleared on reset and on every accepted start).
//  Revision : 1.0 - initial release
// ============================================================================
module simon_key_expand
    import simon_pkg::*;
#(
    parameter int ROUNDS = SIMON_ROUNDS,
    parameter int WORD_W = SIMON_WORD_W
) (
    input wire                clk,
    input wire                res,
    simon_key_expand_if.slave bus
);

    simon_state_t           r_state;
    logic [SIMON_IDX_W-1:0] r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic [WORD_W-1:0]      r_rk_data;
    logic [WORD_W-1:0]      r_keys [ROUNDS];

    logic                   w_accept;
    logic                   w_expand_wr;
    logic [WORD_W-1:0]      w_k_m4;
    logic [WORD_W-1:0]      w_k_m3;
    logic [WORD_W-1:0]      w_k_m1;
    logic [WORD_W-1:0]      w_round;
    logic                   w_z;
    logic                   w_we [ROUNDS];
    logic [WORD_W-1:0]      w_wd [ROUNDS];

    assign w_accept    = !res && bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_expand_wr = !res && (r_state == ST_EXPAND);

    assign w_k_m4 = r_keys[r_idx - 6'd4];
    assign w_k_m3 = r_keys[r_idx - 6'd3];
    assign w_k_m1 = r_keys[r_idx - 6'd1];
    assign w_z    = simon_z_bit(r_idx - 6'd4);

    simon_key_round #(
        .WORD_W (WORD_W)
    ) u_round (
        .i_k_m4 (w_k_m4),
        .i_k_m3 (w_k_m3),
        .i_k_m1 (w_k_m1),
        .i_z    (w_z),
        .o_k    (w_round)
    );

    // Per-word write enables: master words load on start, the rest follow r_idx.
    for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_word
        if (gi < SIMON_KEY_WORDS) begin : g_master
            assign w_we[gi] = w_accept;
            assign w_wd[gi] = bus.key_in[gi*WORD_W +: WORD_W];
        end else begin : g_sched
`ifdef SIMON_KEY_ZEROIZE_EN
            assign w_we[gi] = w_accept || (w_expand_wr && (r_idx == SIMON_IDX_W'(gi)));
            assign w_wd[gi] = w_accept ? '0 : w_round;
`else
            assign w_we[gi] = w_expand_wr && (r_idx == SIMON_IDX_W'(gi));
            assign w_wd[gi] = w_round;
`endif
        end
    end

    always_ff @(posedge clk) begin : p_storage
`ifdef SIMON_KEY_ZEROIZE_EN
        if (res) begin
            for (int w = 0; w < ROUNDS; w++) begin
                r_keys[w] <= '0;
            end
        end else begin
            for (int w = 0; w < ROUNDS; w++) begin
                if (w_we[w]) begin
                    r_keys[w] <= w_wd[w];
                end
            end
        end
`else
        for (int w = 0; w < ROUNDS; w++) begin
            if (w_we[w]) begin
                r_keys[w] <= w_wd[w];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin : p_fsm
        if (res) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state <= ST_EXPAND;
                        r_idx   <= SIMON_IDX_W'(SIMON_KEY_WORDS);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    // The counter parks on the last index once the schedule is written.
                    if (r_idx == SIMON_IDX_W'(ROUNDS - 1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin : p_read
        if (res) begin
            r_rk_data <= '0;
        end else if (bus.rk_addr < SIMON_IDX_W'(ROUNDS)) begin
            r_rk_data <= r_keys[bus.rk_addr];
        end else begin
            r_rk_data <= '0;
        end
    end

    assign bus.rk_data  = r_rk_data;
    assign bus.busy     = r_busy;
    assign bus.key_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_simon_key_expand.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_key_expand
//  Brief    : Self-checking bench for simon_key_expand against a behavioural
//             key-schedule model and the published Simon 64/128 test vector.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simon_key_expand;

    logic clk = 1'b0;
    logic res = 1'b1;

    always #5 clk = ~clk;

    simon_key_expand_if bus ();

    simon_key_expand #(
        .ROUNDS (44),
        .WORD_W (32)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    int          total = 0;
    int          bad   = 0;
    int          cnt;
    int          addr;
    string       z3_seq = "11011011101011000110010111100000010010001010011100110100001111";
    logic [31:0] m_keys [44];
    logic [31:0] m_prev [44];
    logic [31:0] d_keys [44];
    logic [127:0] key_a;
    logic [127:0] key_b;
    int          oob [3] = '{44, 50, 63};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Key schedule written straight from the Simon 64/128 definition.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] tmp;
        logic        zb;
        for (int i = 0; i < 4; i++) m_keys[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            zb  = (z3_seq[(i - 4) % 62] == "1");
            tmp = ror(m_keys[i-1], 3) ^ m_keys[i-3];
            tmp = tmp ^ ror(tmp, 1);
            m_keys[i] = ~m_keys[i-4] ^ tmp ^ {31'b0, zb} ^ 32'h3;
        end
    endtask

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [31:0] x, y, t;
        x = pt[63:32];
        y = pt[31:0];
        for (int r = 0; r < 44; r++) begin
            t = x;
            x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ d_keys[r];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [127:0] key);
        bus.start  = 1'b1;
        bus.key_in = key;
        tick();
        bus.start  = 1'b0;
        bus.key_in = rand_key();
    endtask

    task automatic wait_done(input string tag, input int already);
        cnt = already;
        while (!bus.key_done && cnt < 100) begin
            tick();
            cnt++;
        end
        check({tag, " latency"}, 64'(cnt), 64'd40);
        check({tag, " busy_low"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 44; a++) begin
            bus.rk_addr = 6'(a);
            tick();
            d_keys[a] = bus.rk_data;
            check($sformatf("%s k%0d", tag, a), 64'(bus.rk_data), 64'(m_keys[a]));
        end
        check({tag, " done_held"}, 64'(bus.key_done), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start   = 1'b0;
        bus.key_in  = '0;
        bus.rk_addr = '0;
        res         = 1'b1;
        tick();
        tick();
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst key_done", 64'(bus.key_done), 64'd0);
        check("rst rk_data", 64'(bus.rk_data), 64'd0);
        res = 1'b0;

        foreach (oob[j]) begin
            bus.rk_addr = 6'(oob[j]);
            tick();
            check($sformatf("oob rd %0d", oob[j]), 64'(bus.rk_data), 64'd0);
        end

        // Published test vector, cross-checked by encrypting with the read-back keys.
        model_expand(128'h1b1a1918_13121110_0b0a0908_03020100);
        pulse_start(128'h1b1a1918_13121110_0b0a0908_03020100);
        check("vec busy_E0", 64'(bus.busy), 64'd1);
        check("vec done_E0", 64'(bus.key_done), 64'd0);
        wait_done("vec", 0);
        read_all("vec");
        check("vec k0 const", 64'(d_keys[0]), 64'h03020100);
        check("vec k3 const", 64'(d_keys[3]), 64'h1b1a1918);
        check("vec cipher", encrypt(64'h656b696c_20646e75), 64'h44c8fc20_b9dfa07a);

        // A second start in the middle of expansion must be ignored.
        key_a = rand_key();
        model_expand(key_a);
        pulse_start(key_a);
        repeat (9) tick();
        bus.start  = 1'b1;
        bus.key_in = rand_key();
        tick();
        bus.start  = 1'b0;
        check("ign busy", 64'(bus.busy), 64'd1);
        wait_done("ign", 10);
        read_all("ign");

        // Reset twenty cycles into expansion.
        pulse_start(rand_key());
        repeat (19) tick();
        res = 1'b1;
        tick();
        res = 1'b0;
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst key_done", 64'(bus.key_done), 64'd0);
        check("midrst rk_data", 64'(bus.rk_data), 64'd0);
        repeat (45) tick();
        check("midrst idle busy", 64'(bus.busy), 64'd0);
        check("midrst idle done", 64'(bus.key_done), 64'd0);

        // Reset and start together: reset wins.
        res        = 1'b1;
        bus.start  = 1'b1;
        bus.key_in = rand_key();
        tick();
        res        = 1'b0;
        bus.start  = 1'b0;
        check("res+start busy", 64'(bus.busy), 64'd0);
        check("res+start done", 64'(bus.key_done), 64'd0);
        tick();
        check("res+start busy2", 64'(bus.busy), 64'd0);

        key_b = rand_key();
        model_expand(key_b);
        pulse_start(key_b);
        wait_done("after_rst", 0);
        read_all("after_rst");

        // Restart from DONE with an all-zero key, probing storage while it is rewritten.
        m_prev = m_keys;
        model_expand(128'h0);
        pulse_start(128'h0);
        check("rs done_fall", 64'(bus.key_done), 64'd0);
        check("rs busy", 64'(bus.busy), 64'd1);
        cnt = 0;
        while (!bus.key_done && cnt < 100) begin
            addr = (cnt == 0) ? 30 : ((cnt + 4 > 43) ? 43 : cnt + 4);
            bus.rk_addr = 6'(addr);
            tick();
            cnt++;
            if (cnt <= 40) begin
`ifdef SIMON_KEY_ZEROIZE_EN
                check($sformatf("rs old k%0d", addr), 64'(bus.rk_data), 64'd0);
`else
                check($sformatf("rs old k%0d", addr), 64'(bus.rk_data), 64'(m_prev[addr]));
`endif
            end
        end
        check("rs latency", 64'(cnt), 64'd40);
        check("rs busy_low", 64'(bus.busy), 64'd0);
        read_all("rs");

        for (int n = 0; n < 3; n++) begin
            key_a = rand_key();
            model_expand(key_a);
            pulse_start(key_a);
            wait_done($sformatf("rnd%0d", n), 0);
            read_all($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
